// File: rtl/timer_ctrl.sv
// timer_ctrl
//   Control stage for the downstream saturating up-counter. Sequences the
//   counter's load and enable inputs through a programmable prescaler,
//   supports one-shot and periodic modes, and raises a one-cycle interrupt
//   pulse on every expiry.
//
// Ports
//   clk, rst          single clock, synchronous active-high reset
//   start_i           pulse: latch configuration and (re)start
//   stop_i            pulse: abort, return to idle (wins over start)
//   periodic_i        mode latched at start (1 = periodic, 0 = one-shot)
//   reload_i          counter start value R, latched at start
//   prescale_i        prescaler divider minus one (P-1), latched at start
//   cnt_load_o        counter load strobe
//   cnt_val_o         counter load value (latched R)
//   cnt_en_o          counter increment enable
//   cnt_overflow_i    registered overflow flag from the counter
//   irq_o             one-cycle expiry pulse (registered)
//   busy_o            state is not IDLE
//   done_o            sticky one-shot completion flag, cleared by start
//
// State  | meaning
// -------+---------------------------------------------------------------
// IDLE   | counter controls low, waiting for start
// LOAD   | one-cycle counter load strobe, prescaler cleared
// RUN    | prescaler divides clk, enable every P cycles until overflow
module timer_ctrl #(
    parameter int WIDTH   = 4,
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               periodic_i,
    input  logic [WIDTH-1:0]   reload_i,
    input  logic [PRESC_W-1:0] prescale_i,
    output logic               cnt_load_o,
    output logic [WIDTH-1:0]   cnt_val_o,
    output logic               cnt_en_o,
    input  logic               cnt_overflow_i,
    output logic               irq_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic [WIDTH-1:0]   reload_q;
    logic [PRESC_W-1:0] presc_cfg_q;
    logic [PRESC_W-1:0] presc_q;
    logic               periodic_q;
    logic               irq_q;
    logic               done_q;

    logic in_load;
    logic in_run;
    logic start_eff;
    logic presc_tc;
    logic expire;

    assign in_load   = (state_q == ST_LOAD);
    assign in_run    = (state_q == ST_RUN);
    assign start_eff = start_i && !stop_i;
    assign presc_tc  = (presc_q == presc_cfg_q);

    // Overflow only counts as an expiry in RUN; a stop or start in the same
    // cycle takes precedence and swallows the interrupt.
    assign expire = in_run && cnt_overflow_i && !stop_i && !start_i;

    always_comb begin
        state_d = state_q;
        if (stop_i) begin
            state_d = ST_IDLE;
        end else if (start_i) begin
            state_d = ST_LOAD;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_LOAD: state_d = ST_RUN;
                ST_RUN: begin
                    if (cnt_overflow_i) begin
                        state_d = periodic_q ? ST_LOAD : ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            reload_q    <= '0;
            presc_cfg_q <= '0;
            periodic_q  <= 1'b0;
            presc_q     <= '0;
            irq_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            irq_q   <= expire;

            if (start_eff) begin
                reload_q    <= reload_i;
                presc_cfg_q <= prescale_i;
                periodic_q  <= periodic_i;
                done_q      <= 1'b0;
            end else if (expire && !periodic_q) begin
                done_q <= 1'b1;
            end

            // Prescaler only advances in RUN; held at zero elsewhere so that
            // the first RUN cycle always starts the divide from zero.
            if (in_run) begin
                presc_q <= presc_tc ? '0 : presc_q + PRESC_W'(1);
            end else begin
                presc_q <= '0;
            end
        end
    end

    assign cnt_load_o = in_load;
    assign cnt_val_o  = reload_q;
    // Masking with overflow keeps a P=1 wrap from issuing a pulse into a
    // counter that has already saturated.
    assign cnt_en_o   = in_run && presc_tc && !cnt_overflow_i;
    assign irq_o      = irq_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = done_q;

endmodule

// File: tb/tb_timer_ctrl.sv
module tb_timer_ctrl;

    localparam int WIDTH   = 4;
    localparam int PRESC_W = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               start_i;
    logic               stop_i;
    logic               periodic_i;
    logic [WIDTH-1:0]   reload_i;
    logic [PRESC_W-1:0] prescale_i;
    logic               cnt_load_o;
    logic [WIDTH-1:0]   cnt_val_o;
    logic               cnt_en_o;
    logic               cnt_overflow_i;
    logic               irq_o;
    logic               busy_o;
    logic               done_o;

    int vectors     = 0;
    int miscompares = 0;

    // Downstream saturating counter, plus a forcing term for idle-overflow tests.
    logic [WIDTH-1:0] m_cnt;
    logic             m_ovf;
    logic             ovf_force;

    logic [4:0] obs;
    logic [4:0] exp_v;

    timer_ctrl #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .stop_i         (stop_i),
        .periodic_i     (periodic_i),
        .reload_i       (reload_i),
        .prescale_i     (prescale_i),
        .cnt_load_o     (cnt_load_o),
        .cnt_val_o      (cnt_val_o),
        .cnt_en_o       (cnt_en_o),
        .cnt_overflow_i (cnt_overflow_i),
        .irq_o          (irq_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt <= '0;
            m_ovf <= 1'b0;
        end else if (cnt_load_o) begin
            m_cnt <= cnt_val_o;
            m_ovf <= 1'b0;
        end else if (cnt_en_o) begin
            if (m_cnt == {WIDTH{1'b1}}) m_ovf <= 1'b1;
            else                        m_cnt <= m_cnt + WIDTH'(1);
        end
    end

    assign cnt_overflow_i = m_ovf | ovf_force;
    assign obs = {cnt_load_o, cnt_en_o, irq_o, busy_o, done_o};

    // Expected {load, en, irq, busy, done} at cycle r after the load cycle L,
    // from the timeline: en at L+kP (k=1..N), irq at L+PN+2, period PN+2.
    function automatic logic [4:0] model_out(input int r, input int p, input int n, input bit per);
        int  t;
        int  q;
        bit  ld, en, irq, busy, done;
        t = p * n + 2;
        q = per ? (r % t) : r;
        ld   = (q == 0);
        en   = (q >= p) && (q <= p * n) && (q % p == 0);
        if (per) begin
            irq  = (q == 0) && (r > 0);
            busy = 1'b1;
            done = 1'b0;
        end else begin
            irq  = (r == t);
            busy = (r < t);
            done = (r >= t);
        end
        return {ld, en, irq, busy, done};
    endfunction

    function automatic int n_of(input int r);
        return (1 << WIDTH) - r;
    endfunction

    // Drives a start with the given configuration; returns at the sample
    // point of the load cycle. Inputs are scrambled afterwards so that any
    // failure to latch shows up.
    task automatic launch(input int r, input int presc, input bit per);
        reload_i   = WIDTH'(r);
        prescale_i = PRESC_W'(presc);
        periodic_i = per;
        start_i    = 1'b1;
        @(negedge clk);
        start_i    = 1'b0;
        reload_i   = WIDTH'($urandom);
        prescale_i = PRESC_W'($urandom);
        periodic_i = 1'($urandom);
    endtask

    task automatic go_idle();
        stop_i = 1'b1;
        @(negedge clk);
        stop_i = 1'b0;
    endtask

    task automatic test_reset_initial();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (obs !== 5'b0 || cnt_val_o !== '0) begin
            miscompares++;
            $display("FAIL reset_init got=%b val=%0d exp=00000 val=0", obs, cnt_val_o);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_oneshot();
        int p = 1, n = n_of(12);
        launch(12, 0, 0);
        vectors++;
        if (cnt_val_o !== WIDTH'(12)) begin
            miscompares++;
            $display("FAIL oneshot_val got=%0d exp=12", cnt_val_o);
        end
        for (int rel = 0; rel <= p * n + 5; rel++) begin
            exp_v = model_out(rel, p, n, 0);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL oneshot rel=%0d got=%b exp=%b", rel, obs, exp_v);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_periodic();
        int p = 3, n = n_of(14);
        launch(14, 2, 1);
        for (int rel = 0; rel <= 3 * (p * n + 2); rel++) begin
            exp_v = model_out(rel, p, n, 1);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL periodic rel=%0d got=%b exp=%b", rel, obs, exp_v);
            end
            @(negedge clk);
        end
        go_idle();
    endtask

    task automatic test_full_range();
        int p = 1, n = n_of(0);
        launch(0, 0, 0);
        for (int rel = 0; rel <= p * n + 4; rel++) begin
            exp_v = model_out(rel, p, n, 0);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL full_range rel=%0d got=%b exp=%b", rel, obs, exp_v);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stop();
        int p = 2, n = n_of(12);
        launch(12, 1, 0);
        for (int rel = 0; rel <= 12; rel++) begin
            exp_v = (rel <= 2 * p) ? model_out(rel, p, n, 0) : 5'b0;
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL stop_mid rel=%0d got=%b exp=%b", rel, obs, exp_v);
            end
            if (rel == 2 * p) stop_i = 1'b1;
            @(negedge clk);
            stop_i = 1'b0;
        end
        start_i = 1'b1;
        stop_i  = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        stop_i  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (obs !== 5'b0) begin
                miscompares++;
                $display("FAIL start_stop_idle cyc=%0d got=%b exp=00000", i, obs);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_restart();
        int n;
        launch(12, 0, 0);
        for (int rel = 0; rel <= 3; rel++) begin
            exp_v = model_out(rel, 1, n_of(12), 0);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL restart_old rel=%0d got=%b exp=%b", rel, obs, exp_v);
            end
            if (rel < 3) @(negedge clk);
        end
        launch(10, 0, 0);
        vectors++;
        if (cnt_val_o !== WIDTH'(10)) begin
            miscompares++;
            $display("FAIL restart_val got=%0d exp=10", cnt_val_o);
        end
        n = n_of(10);
        for (int rel = 0; rel <= n + 4; rel++) begin
            exp_v = model_out(rel, 1, n, 0);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL restart_new rel=%0d got=%b exp=%b", rel, obs, exp_v);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        n = n_of(13);
        launch(13, 0, 0);
        for (int rel = 0; rel <= n + 1; rel++) begin
            exp_v = model_out(rel, 1, n, 0);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL b2b_old rel=%0d got=%b exp=%b", rel, obs, exp_v);
            end
            if (rel < n + 1) @(negedge clk);
        end
        // now in the overflow cycle: a start here must suppress the irq
        launch(15, 1, 0);
        n = n_of(15);
        for (int rel = 0; rel <= 2 * n + 4; rel++) begin
            exp_v = model_out(rel, 2, n, 0);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL b2b_new rel=%0d got=%b exp=%b", rel, obs, exp_v);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int r, pr, p, n, t, len;
        bit per;
        for (int it = 0; it < 8; it++) begin
            r   = int'($urandom_range(0, 15));
            pr  = int'($urandom_range(0, 3));
            per = 1'($urandom_range(0, 1));
            p   = pr + 1;
            n   = n_of(r);
            t   = p * n + 2;
            len = per ? 2 * t + 2 : t + 3;
            launch(r, pr, per);
            vectors++;
            if (cnt_val_o !== WIDTH'(r)) begin
                miscompares++;
                $display("FAIL random_val it=%0d got=%0d exp=%0d", it, cnt_val_o, r);
            end
            for (int rel = 0; rel <= len; rel++) begin
                exp_v = model_out(rel, p, n, per);
                vectors++;
                if (obs !== exp_v) begin
                    miscompares++;
                    $display("FAIL random it=%0d R=%0d P=%0d per=%0d rel=%0d got=%b exp=%b",
                             it, r, p, per, rel, obs, exp_v);
                end
                @(negedge clk);
            end
            go_idle();
        end
    endtask

    task automatic test_reset();
        int p = 3, n = n_of(14);
        launch(14, 2, 1);
        for (int rel = 0; rel <= p * n + 1; rel++) begin
            exp_v = model_out(rel, p, n, 1);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL reset_run rel=%0d got=%b exp=%b", rel, obs, exp_v);
            end
            if (rel < p * n + 1) @(negedge clk);
        end
        // overflow cycle: reset here must drop the pending irq
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (obs !== 5'b0 || cnt_val_o !== '0) begin
                miscompares++;
                $display("FAIL reset_mid cyc=%0d got=%b val=%0d exp=00000 val=0", i, obs, cnt_val_o);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ovf_force = (i % 2 == 0);
            @(negedge clk);
            vectors++;
            if (obs !== 5'b0) begin
                miscompares++;
                $display("FAIL idle_ovf cyc=%0d got=%b exp=00000", i, obs);
            end
        end
        ovf_force = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        start_i    = 1'b0;
        stop_i     = 1'b0;
        periodic_i = 1'b0;
        reload_i   = '0;
        prescale_i = '0;
        ovf_force  = 1'b0;
        test_reset_initial();
        test_oneshot();
        test_periodic();
        test_full_range();
        test_stop();
        test_restart();
        test_back_to_back();
        test_random();
        test_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached vectors=%0d", vectors);
        $fatal(1);
    end

endmodule
